// File: rtl/pixel_array_sequencer_if.sv
// Signal bundle between the pixel array sequencer, the pixel array and the frame buffer.
// The master side is the sequencer; the slave side is the array/frame-buffer environment.
interface pixel_array_sequencer_if #(
   parameter int ROWS = 2,
   parameter int COLS = 2,
   parameter int BITS = 8
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic                   start;
   logic [15:0]            expose_cycles;
   logic                   busy;
   logic                   ERASE;
   logic                   EXPOSE;
   logic                   CONVERT;
   logic [BITS-1:0]        CNT_DATA;
   logic [ROWS-1:0]        READ;
   logic [COLS*BITS-1:0]   ROW_DATA;
   logic [COLS*BITS-1:0]   out_data;
   logic [RW-1:0]          out_row;
   logic                   out_valid;
   logic                   out_ready;
   logic                   frame_done;

   modport master (
      input  start, expose_cycles, ROW_DATA, out_ready,
      output busy, ERASE, EXPOSE, CONVERT, CNT_DATA, READ,
             out_data, out_row, out_valid, frame_done
   );

   modport slave (
      output start, expose_cycles, ROW_DATA, out_ready,
      input  busy, ERASE, EXPOSE, CONVERT, CNT_DATA, READ,
             out_data, out_row, out_valid, frame_done
   );
endinterface

// File: rtl/pixel_array_sequencer.sv
// Frame sequencer for a ROWS x COLS pixel array: erase, expose, ramp-convert, then
// row-by-row readout onto a valid/ready bus toward the frame buffer.
module pixel_array_sequencer #(
   parameter int ROWS      = 2,
   parameter int COLS      = 2,
   parameter int BITS      = 8,
   parameter int ERASE_CYC = 5,
   parameter int GRAY      = 0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   pixel_array_sequencer_if.master bus
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ERASE   = 3'd1;
   localparam logic [2:0] S_EXPOSE  = 3'd2;
   localparam logic [2:0] S_CONVERT = 3'd3;
   localparam logic [2:0] S_RD_SEL  = 3'd4;
   localparam logic [2:0] S_RD_CAP  = 3'd5;
   localparam logic [2:0] S_RD_WAIT = 3'd6;

   localparam logic [15:0]   ERASE_LAST = 16'(ERASE_CYC - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

   logic [2:0]           state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [15:0]          exp_len_q, exp_len_d;
   logic [BITS-1:0]      k_q, k_d;
   logic [RW-1:0]        row_q, row_d;
   logic [COLS*BITS-1:0] out_data_q, out_data_d;
   logic [RW-1:0]        out_row_q, out_row_d;
   logic                 out_valid_q, out_valid_d;
   logic                 frame_done_q, frame_done_d;
   logic [BITS-1:0]      code;
   logic                 read_act;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      exp_len_d    = exp_len_q;
      k_d          = k_q;
      row_d        = row_q;
      out_data_d   = out_data_q;
      out_row_d    = out_row_q;
      out_valid_d  = out_valid_q;
      frame_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               // A zero exposure request still gets one EXPOSE cycle.
               exp_len_d = (bus.expose_cycles == 16'd0) ? 16'd1 : bus.expose_cycles;
               cnt_d     = '0;
               state_d   = S_ERASE;
            end
         end
         S_ERASE: begin
            if (cnt_q == ERASE_LAST) begin
               cnt_d   = '0;
               state_d = S_EXPOSE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_EXPOSE: begin
            if (cnt_q == exp_len_q - 16'd1) begin
               k_d     = '0;
               state_d = S_CONVERT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_CONVERT: begin
            k_d = k_q + 1'b1;
            if (&k_q) begin
               row_d   = '0;
               state_d = S_RD_SEL;
            end
         end
         S_RD_SEL: begin
            state_d = S_RD_CAP;
         end
         S_RD_CAP: begin
            out_data_d  = bus.ROW_DATA;
            out_row_d   = row_q;
            out_valid_d = 1'b1;
            state_d     = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (row_q == ROW_LAST) begin
                  frame_done_d = 1'b1;
                  state_d      = S_IDLE;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = S_RD_SEL;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         exp_len_q    <= '0;
         k_q          <= '0;
         row_q        <= '0;
         out_data_q   <= '0;
         out_row_q    <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         exp_len_q    <= exp_len_d;
         k_q          <= k_d;
         row_q        <= row_d;
         out_data_q   <= out_data_d;
         out_row_q    <= out_row_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   generate
      if (GRAY != 0) begin : g_gray
         assign code = k_q ^ (k_q >> 1);
      end else begin : g_bin
         assign code = k_q;
      end
   endgenerate

   // Row select is asserted for the settle cycle and the capture cycle only.
   assign read_act = (state_q == S_RD_SEL) || (state_q == S_RD_CAP);

   generate
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_read
         assign bus.READ[gi] = read_act && (row_q == RW'(gi));
      end
   endgenerate

   assign bus.busy       = (state_q != S_IDLE);
   assign bus.ERASE      = (state_q == S_ERASE);
   assign bus.EXPOSE     = (state_q == S_EXPOSE);
   assign bus.CONVERT    = (state_q == S_CONVERT);
   assign bus.CNT_DATA   = (state_q == S_CONVERT) ? code : '0;
   assign bus.out_data   = out_data_q;
   assign bus.out_row    = out_row_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_pixel_array_sequencer.sv
// Directed bench for pixel_array_sequencer: a default 2x2x8 binary instance and a
// 3x4x4 Gray instance, with a row scoreboard filled at frame start and drained on handshakes.
module tb_pixel_array_sequencer;
   typedef struct {
      int          row;
      logic [47:0] data;
   } exp_t;

   logic clk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   frame_a = 0;
   int   frame_b = 0;
   exp_t qa[$];
   exp_t qb[$];
   logic        pv[2];
   logic        pr[2];
   int          prow[2];
   logic [47:0] pdata[2];
   logic [47:0] wa, wb;
   logic [3:0]  prev_cnt;
   int          gray_tab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

   pixel_array_sequencer_if #(.ROWS(2), .COLS(2), .BITS(8)) ifa ();
   pixel_array_sequencer_if #(.ROWS(3), .COLS(4), .BITS(4)) ifb ();

   pixel_array_sequencer #(.ROWS(2), .COLS(2), .BITS(8), .ERASE_CYC(5), .GRAY(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(ifa)
   );
   pixel_array_sequencer #(.ROWS(3), .COLS(4), .BITS(4), .ERASE_CYC(3), .GRAY(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [47:0] row_word(input int fr, input int r, input int cols, input int bits);
      logic [47:0] w;
      int v;
      w = '0;
      for (int c = 0; c < cols; c++) begin
         v = fr * 37 + r * 11 + c * 5 + 3;
         for (int b = 0; b < bits; b++) w[c*bits+b] = v[b];
      end
      return w;
   endfunction

   // Pixel array model: the selected row presents a frame-dependent pattern.
   always_comb begin
      wa = 48'h5A5A5A5A5A5A;
      for (int r = 0; r < 2; r++) if (ifa.READ[r]) wa = row_word(frame_a, r, 2, 8);
      ifa.ROW_DATA = wa[15:0];
   end
   always_comb begin
      wb = 48'hA5A5A5A5A5A5;
      for (int r = 0; r < 3; r++) if (ifb.READ[r]) wb = row_word(frame_b, r, 4, 4);
      ifb.ROW_DATA = wb[15:0];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic mon(input int i, input logic v, input logic rdy, input int row, input logic [47:0] data);
      exp_t e;
      int   pending;
      if (v && pv[i] && !pr[i]) begin
         check($sformatf("hold_row%0d", i), 64'(row), 64'(prow[i]));
         check($sformatf("hold_data%0d", i), 64'(data), 64'(pdata[i]));
      end
      if (v && rdy) begin
         pending = (i == 0) ? qa.size() : qb.size();
         check($sformatf("row_pending%0d", i), 64'(pending > 0), 64'(1));
         if (pending > 0) begin
            if (i == 0) e = qa.pop_front();
            else e = qb.pop_front();
            check($sformatf("out_row%0d", i), 64'(row), 64'(e.row));
            check($sformatf("out_data%0d", i), 64'(data), 64'(e.data));
         end
      end
      pv[i]    = v;
      pr[i]    = rdy;
      prow[i]  = row;
      pdata[i] = data;
   endtask

   always @(negedge clk) begin
      mon(0, ifa.out_valid, ifa.out_ready, int'(ifa.out_row), 48'(ifa.out_data));
      mon(1, ifb.out_valid, ifb.out_ready, int'(ifb.out_row), 48'(ifb.out_data));
      check("excl_a", 64'($countones({ifa.ERASE, ifa.EXPOSE, ifa.CONVERT, |ifa.READ}) <= 1), 64'(1));
      check("excl_b", 64'($countones({ifb.ERASE, ifb.EXPOSE, ifb.CONVERT, |ifb.READ}) <= 1), 64'(1));
   end

   task automatic start_a(input int e);
      exp_t x;
      ifa.expose_cycles = 16'(e);
      frame_a++;
      for (int r = 0; r < 2; r++) begin
         x.row  = r;
         x.data = row_word(frame_a, r, 2, 8);
         qa.push_back(x);
      end
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
   endtask

   task automatic erase_expose_a(input int elen);
      for (int i = 0; i < 5; i++) begin
         check("a_erase", 64'({ifa.ERASE, ifa.EXPOSE, ifa.CONVERT, ifa.busy}), 64'(4'b1001));
         tick();
      end
      for (int i = 0; i < elen; i++) begin
         check("a_expose", 64'({ifa.ERASE, ifa.EXPOSE, ifa.CONVERT, ifa.busy}), 64'(4'b0101));
         tick();
      end
   endtask

   task automatic convert_a(input int from, input int to);
      for (int k = from; k < to; k++) begin
         check("a_cnt", 64'({ifa.CONVERT, ifa.CNT_DATA}), 64'({1'b1, 8'(k)}));
         tick();
      end
   endtask

   task automatic readout_a();
      for (int r = 0; r < 2; r++) begin
         check("a_rdsel", 64'({ifa.READ, ifa.CNT_DATA}), 64'({2'(1 << r), 8'd0}));
         tick();
         check("a_rdcap", 64'(ifa.READ), 64'(1 << r));
         tick();
         check("a_rdwait", 64'({ifa.READ, ifa.out_valid, ifa.out_row}), 64'({2'b00, 1'b1, 1'(r)}));
         tick();
      end
      check("a_done", 64'({ifa.frame_done, ifa.busy, ifa.out_valid}), 64'(3'b100));
      tick();
      check("a_after", 64'({ifa.frame_done, ifa.busy}), 64'(2'b00));
   endtask

   task automatic start_b(input int e);
      exp_t x;
      ifb.expose_cycles = 16'(e);
      frame_b++;
      for (int r = 0; r < 3; r++) begin
         x.row  = r;
         x.data = row_word(frame_b, r, 4, 4);
         qb.push_back(x);
      end
      ifb.start = 1'b1;
      tick();
      ifb.start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         pv[i] = 1'b0; pr[i] = 1'b0; prow[i] = 0; pdata[i] = '0;
      end
      reset_n           = 1'b0;
      ifa.start         = 1'($urandom);
      ifa.expose_cycles = 16'($urandom);
      ifa.out_ready     = 1'($urandom);
      ifb.start         = 1'($urandom);
      ifb.expose_cycles = 16'($urandom);
      ifb.out_ready     = 1'($urandom);
      #23;
      check("rst_a", 64'({ifa.busy, ifa.ERASE, ifa.EXPOSE, ifa.CONVERT, ifa.CNT_DATA, ifa.READ,
                          ifa.out_data, ifa.out_row, ifa.out_valid, ifa.frame_done}), 64'(0));
      check("rst_b", 64'({ifb.busy, ifb.ERASE, ifb.EXPOSE, ifb.CONVERT, ifb.CNT_DATA, ifb.READ,
                          ifb.out_data, ifb.out_row, ifb.out_valid, ifb.frame_done}), 64'(0));
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      reset_n   = 1'b1;
      repeat (10) tick();
      check("idle_a", 64'({ifa.busy, ifa.ERASE, ifa.EXPOSE, ifa.CONVERT, ifa.CNT_DATA, ifa.READ,
                           ifa.out_valid, ifa.frame_done}), 64'(0));
      check("idle_b", 64'({ifb.busy, ifb.ERASE, ifb.EXPOSE, ifb.CONVERT, ifb.CNT_DATA, ifb.READ,
                           ifb.out_valid, ifb.frame_done}), 64'(0));

      // Nominal frame on the default instance.
      ifa.out_ready = 1'b1;
      start_a(3);
      erase_expose_a(3);
      convert_a(0, 256);
      readout_a();

      // Zero exposure becomes one cycle; start during CONVERT is ignored.
      start_a(0);
      erase_expose_a(1);
      convert_a(0, 128);
      ifa.start = 1'b1;
      convert_a(128, 129);
      ifa.start = 1'b0;
      convert_a(129, 256);
      readout_a();

      // Reset in the middle of CONVERT, then a clean frame.
      start_a(3);
      erase_expose_a(3);
      convert_a(0, 100);
      check("a_k100", 64'(ifa.CNT_DATA), 64'(100));
      reset_n = 1'b0;
      #1;
      check("a_midrst", 64'({ifa.busy, ifa.ERASE, ifa.EXPOSE, ifa.CONVERT, ifa.CNT_DATA, ifa.READ,
                             ifa.out_data, ifa.out_row, ifa.out_valid, ifa.frame_done}), 64'(0));
      qa.delete();
      tick();
      reset_n = 1'b1;
      tick();
      check("a_rst_nodone", 64'({ifa.frame_done, ifa.busy}), 64'(0));
      start_a(3);
      erase_expose_a(3);
      convert_a(0, 256);
      readout_a();

      // Gray instance with backpressure on row 1.
      ifb.out_ready = 1'b1;
      start_b(2);
      for (int i = 0; i < 3; i++) begin
         check("b_erase", 64'({ifb.ERASE, ifb.EXPOSE, ifb.CONVERT, ifb.busy}), 64'(4'b1001));
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         check("b_expose", 64'({ifb.ERASE, ifb.EXPOSE, ifb.CONVERT, ifb.busy}), 64'(4'b0101));
         tick();
      end
      prev_cnt = '0;
      for (int k = 0; k < 16; k++) begin
         check("b_gray", 64'({ifb.CONVERT, ifb.CNT_DATA}), 64'({1'b1, 4'(gray_tab[k])}));
         if (k > 0) check("b_gray_step", 64'($countones(ifb.CNT_DATA ^ prev_cnt)), 64'(1));
         prev_cnt = ifb.CNT_DATA;
         tick();
      end
      for (int r = 0; r < 3; r++) begin
         if (r == 1) ifb.out_ready = 1'b0;
         check("b_rdsel", 64'(ifb.READ), 64'(1 << r));
         tick();
         check("b_rdcap", 64'(ifb.READ), 64'(1 << r));
         tick();
         if (r == 1) begin
            for (int w = 0; w < 7; w++) begin
               check("b_bp", 64'({ifb.READ, ifb.out_valid, ifb.out_row}), 64'({3'b000, 1'b1, 2'd1}));
               tick();
            end
            ifb.out_ready = 1'b1;
         end
         check("b_rdwait", 64'({ifb.READ, ifb.out_valid, ifb.out_row}), 64'({3'b000, 1'b1, 2'(r)}));
         tick();
      end
      check("b_done", 64'({ifb.frame_done, ifb.busy, ifb.out_valid}), 64'(3'b100));
      tick();
      check("b_after", 64'({ifb.frame_done, ifb.busy}), 64'(2'b00));

      check("qa_empty", 64'(qa.size()), 64'(0));
      check("qb_empty", 64'(qb.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
